// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
//   Sequences one weight tile into SYS_COLS per-column FIFOs and then streams
//   it into the systolic array.
//   Load: words arrive column-major on a valid/ready handshake and are written
//   one cycle later to the FIFO of the current column.
//   Read: a ROWS-cycle read strobe goes to column 0. A drain phase of
//   SYS_COLS-1 cycles then covers the downstream per-column skew, and
//   read_done pulses on its final cycle.
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start_load         one-cycle request to load a tile (honoured in IDLE only)
//   w_valid/w_data     incoming weight word
//   w_ready            high while loading
//   wr_en/wr_data      per-column FIFO write strobe (one-hot) / data (all lanes equal)
//   start_read         one-cycle request to stream the tile (honoured in LOADED only)
//   read               read strobe to column 0
//   load_done          pulse with the final FIFO write of a tile
//   read_done          pulse on the last drain cycle
//   busy               high outside IDLE
module weight_buffer_ctrl #(
  parameter int unsigned SYS_COLS   = 4,
  parameter int unsigned W_BITWIDTH = 8,
  parameter int unsigned ROWS       = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start_load,
  input  logic                           w_valid,
  input  logic [W_BITWIDTH-1:0]          w_data,
  output logic                           w_ready,
  output logic [SYS_COLS-1:0]            wr_en,
  output logic [SYS_COLS*W_BITWIDTH-1:0] wr_data,
  input  logic                           start_read,
  output logic                           read,
  output logic                           load_done,
  output logic                           read_done,
  output logic                           busy
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(SYS_COLS);
  localparam int unsigned SW = (SYS_COLS > 2) ? $clog2(SYS_COLS - 1) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SYS_COLS - 1);
  localparam logic [SW-1:0] SK_LAST  = SW'(SYS_COLS - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    READ,
    DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] rd_cnt;
  logic [SW-1:0] sk_cnt;

  logic accept;
  logic load_last;
  logic rd_last;
  logic sk_last;

  assign accept    = w_valid && (state == LOAD);
  assign load_last = accept && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
  assign rd_last   = (rd_cnt == ROW_LAST);
  assign sk_last   = (sk_cnt == SK_LAST);

  assign w_ready   = (state == LOAD);
  assign busy      = (state != IDLE);
  assign read_done = (state == DRAIN) && sk_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_load) state_nxt = LOAD;
      LOAD:    if (load_last)  state_nxt = LOADED;
      LOADED:  if (start_read) state_nxt = READ;
      READ:    if (rd_last)    state_nxt = DRAIN;
      DRAIN:   if (sk_last)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Load address counters; the final accept wraps both back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (accept) begin
      if (row_cnt == ROW_LAST) begin
        row_cnt <= '0;
        col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + CW'(1);
      end else begin
        row_cnt <= row_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      sk_cnt <= '0;
    end else begin
      if (state == READ)  rd_cnt <= rd_last ? '0 : rd_cnt + RW'(1);
      if (state == DRAIN) sk_cnt <= sk_last ? '0 : sk_cnt + SW'(1);
    end
  end

  // Registered outputs. read is derived from the next state so that it is
  // high exactly during the READ cycles without an extra cycle of latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en     <= '0;
      wr_data   <= '0;
      read      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < SYS_COLS; c++) begin
        wr_en[c] <= accept && (col_cnt == CW'(c));
      end
      if (accept) wr_data <= {SYS_COLS{w_data}};
      read      <= (state_nxt == READ);
      load_done <= load_last;
    end
  end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
module tb_weight_buffer_ctrl;

  localparam int unsigned SYS_COLS   = 4;
  localparam int unsigned W_BITWIDTH = 8;
  localparam int unsigned ROWS       = 3;

  logic                           clk;
  logic                           rstn;
  logic                           start_load;
  logic                           w_valid;
  logic [W_BITWIDTH-1:0]          w_data;
  logic                           w_ready;
  logic [SYS_COLS-1:0]            wr_en;
  logic [SYS_COLS*W_BITWIDTH-1:0] wr_data;
  logic                           start_read;
  logic                           read;
  logic                           load_done;
  logic                           read_done;
  logic                           busy;

  int checks = 0;
  int errors = 0;

  // Write log captured away from the clock edge.
  logic [SYS_COLS-1:0]            q_en[$];
  logic [SYS_COLS*W_BITWIDTH-1:0] q_data[$];
  logic                           q_done[$];
  int                             done_cnt;

  weight_buffer_ctrl #(
    .SYS_COLS  (SYS_COLS),
    .W_BITWIDTH(W_BITWIDTH),
    .ROWS      (ROWS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_load(start_load),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .start_read(start_read),
    .read      (read),
    .load_done (load_done),
    .read_done (read_done),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr_en != '0 || load_done) begin
      q_en.push_back(wr_en);
      q_data.push_back(wr_data);
      q_done.push_back(load_done);
    end
    if (load_done) done_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    q_en.delete();
    q_data.delete();
    q_done.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start_load = 1'b0; start_read = 1'b0; w_valid = 1'b0; w_data = '0;
    step(); step();
    checks++;
    if ({busy, w_ready, read, load_done, read_done} !== 5'b0 || wr_en !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b w_ready=%b read=%b ld=%b rd=%b wr_en=%b wr_data=%h, required all 0",
               busy, w_ready, read, load_done, read_done, wr_en, wr_data);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b w_ready=%b, required 0 0", busy, w_ready);
    end
  endtask

  // Loads one tile of 12 words 0x01..0x0C, optionally with a bubble after each word.
  task automatic test_load(input bit gap, input string name);
    logic [W_BITWIDTH-1:0] exp_word;
    logic [SYS_COLS-1:0]   exp_en;
    clear_log();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    checks++;
    if (w_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_enter_load: w_ready=%b busy=%b, required 1 1", name, w_ready, busy);
    end
    for (int k = 1; k <= 12; k++) begin
      w_valid = 1'b1;
      w_data  = 8'(k);
      step();
      if (gap) begin
        w_valid = 1'b0;
        w_data  = 8'hFF;
        step();
      end
    end
    w_valid = 1'b0;
    w_data  = 8'hEE;
    step(); step();
    checks++;
    if (q_en.size() != 12) begin
      errors++;
      $display("FAIL %s_write_count: got %0d writes, required 12", name, q_en.size());
    end
    for (int i = 0; i < 12 && i < q_en.size(); i++) begin
      exp_word = 8'(i + 1);
      exp_en   = 4'b0001 << (i / 3);
      checks++;
      if (q_en[i] !== exp_en || q_data[i] !== {SYS_COLS{exp_word}} || q_done[i] !== (i == 11)) begin
        errors++;
        $display("FAIL %s_write%0d: wr_en=%b wr_data=%h load_done=%b, required %b %h %b",
                 name, i, q_en[i], q_data[i], q_done[i], exp_en, {SYS_COLS{exp_word}}, (i == 11));
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_load_done_count: got %0d, required 1", name, done_cnt);
    end
    checks++;
    if (busy !== 1'b1 || w_ready !== 1'b0 || read !== 1'b0) begin
      errors++;
      $display("FAIL %s_loaded_state: busy=%b w_ready=%b read=%b, required 1 0 0", name, busy, w_ready, read);
    end
  endtask

  // From LOADED: start_read in cycle T; cycle c below is T+c.
  task automatic test_read(input bit poke_load, input string name);
    logic e_read, e_done, e_busy;
    start_read = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start_read = 1'b0;
      start_load = poke_load && (c <= 3);
      e_read = (c <= 3);
      e_done = (c == 6);
      e_busy = (c <= 6);
      checks++;
      if (read !== e_read || read_done !== e_done || busy !== e_busy || w_ready !== 1'b0 || wr_en !== '0) begin
        errors++;
        $display("FAIL %s_T+%0d: read=%b read_done=%b busy=%b w_ready=%b wr_en=%b, required %b %b %b 0 0",
                 name, c, read, read_done, busy, w_ready, wr_en, e_read, e_done, e_busy);
      end
    end
    start_load = 1'b0;
  endtask

  task automatic test_idle_start_read;
    clear_log();
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || read !== 1'b0 || w_ready !== 1'b0 || read_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_start_read%0d: busy=%b read=%b w_ready=%b read_done=%b, required 0 0 0 0",
                 c, busy, read, w_ready, read_done);
      end
      step();
    end
    checks++;
    if (q_en.size() != 0) begin
      errors++;
      $display("FAIL idle_start_read_writes: got %0d writes, required 0", q_en.size());
    end
  endtask

  task automatic test_reset_mid_load;
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      w_valid = 1'b1;
      w_data  = 8'(8'h80 + k);
      step();
    end
    w_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, w_ready, read, load_done, read_done} !== 5'b0 || wr_en !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: busy=%b w_ready=%b read=%b ld=%b rd=%b wr_en=%b wr_data=%h, required all 0",
               busy, w_ready, read, load_done, read_done, wr_en, wr_data);
    end
    step();
    rstn = 1'b1;
    clear_log();
    step(); step(); step();
    checks++;
    if (busy !== 1'b0 || w_ready !== 1'b0 || wr_data !== '0 || q_en.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_load_quiet: busy=%b w_ready=%b wr_data=%h writes=%0d, required 0 0 0 0",
               busy, w_ready, wr_data, q_en.size());
    end
    test_load(1'b0, "reload");
  endtask

  task automatic test_reset_mid_read;
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    step();
    checks++;
    if (read !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_active: read=%b, required 1", read);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || busy !== 1'b0 || read_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: read=%b busy=%b read_done=%b, required 0 0 0", read, busy, read_done);
    end
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_both_starts;
    start_load = 1'b1;
    start_read = 1'b1;
    step();
    start_load = 1'b0;
    start_read = 1'b0;
    checks++;
    if (w_ready !== 1'b1 || read !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_starts: w_ready=%b read=%b busy=%b, required 1 0 1", w_ready, read, busy);
    end
    step(); step();
    checks++;
    if (w_ready !== 1'b1 || read !== 1'b0) begin
      errors++;
      $display("FAIL both_starts_hold: w_ready=%b read=%b, required 1 0", w_ready, read);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    done_cnt = 0;
    test_reset();
    test_load(1'b0, "b2b");
    test_read(1'b0, "read");
    test_idle_start_read();
    test_load(1'b1, "gapped");
    test_read(1'b1, "read_poke");
    test_reset_mid_load();
    test_reset_mid_read();
    test_both_starts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_buffer_ctrl.md
WEIGHT_BUFFER_CTRL -- requirements
Module: weight_buffer_ctrl

Interface
REQ-001 Parameter SYS_COLS, default sys_cols: number of weight columns (per-column FIFOs) sequenced; SHALL be >= 2.
REQ-002 Parameter W_BITWIDTH, default W_BITWIDTH: width of one weight word.
REQ-003 Parameter ROWS, default super_w_rows: words per column in one weight tile; SHALL be >= 1 and <= w_buffer_depth.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start_load  input  1  one-cycle request to begin loading one weight tile.
REQ-007 w_valid  input  1  incoming weight word valid.
REQ-008 w_data  input  W_BITWIDTH  incoming weight word, column-major (column 0 rows 0..ROWS-1, then column 1, ...).
REQ-009 w_ready  output  1  controller accepts w_data this cycle.
REQ-010 wr_en  output  SYS_COLS  per-column FIFO write enable, at most one bit set.
REQ-011 wr_data  output  SYS_COLS x W_BITWIDTH  per-column write data; every lane carries the same word.
REQ-012 start_read  input  1  one-cycle request to stream the loaded tile into the array.
REQ-013 read  output  1  read strobe to column 0; downstream skew chain delays it per column.
REQ-014 load_done  output  1  one-cycle pulse: tile fully written.
REQ-015 read_done  output  1  one-cycle pulse: last column has received its last read.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, LOAD, LOADED, READ, DRAIN; encoding is free.
REQ-018 IDLE -> LOAD on start_load; start_read in IDLE SHALL be ignored.
REQ-019 w_ready SHALL be 1 exactly while in LOAD (combinational from state).
REQ-020 Handshake: a word is accepted on a cycle with w_valid && w_ready; w_valid without w_ready SHALL have no effect.
REQ-021 LOAD keeps row_cnt (0..ROWS-1) and col_cnt (0..SYS_COLS-1); each accept SHALL increment row_cnt, wrapping to 0 and incrementing col_cnt at ROWS-1.
REQ-022 Write latency SHALL be one cycle: the cycle after an accept, wr_en has only bit col_cnt(at accept) set and wr_data holds the accepted word; otherwise wr_en = 0.
REQ-023 The accept at row_cnt = ROWS-1 and col_cnt = SYS_COLS-1 SHALL move LOAD -> LOADED, clear both counters, and pulse load_done on the same cycle as the final wr_en.
REQ-024 Gaps in w_valid SHALL stall the counters; no word is skipped or duplicated.
REQ-025 LOADED -> READ on start_read; start_load in LOADED, READ or DRAIN SHALL be ignored.
REQ-026 READ: read SHALL be registered, high for exactly ROWS consecutive cycles starting the cycle after start_read is sampled, counted by rd_cnt.
REQ-027 After the last read cycle the FSM SHALL enter DRAIN for exactly SYS_COLS-1 cycles (skew counter), read = 0.
REQ-028 read_done SHALL pulse on the final DRAIN cycle, i.e. SYS_COLS-1 cycles after the last read high cycle; next state IDLE.
REQ-029 start_load and start_read both high in IDLE SHALL take start_load only.
REQ-030 Counter widths SHALL be $clog2 of their range, minimum 1 bit; no overflow past terminal values.

Reset
REQ-031 rstn low SHALL immediately force IDLE, all counters 0, wr_en = 0, wr_data = 0, read = 0, load_done = 0, read_done = 0, busy = 0, w_ready = 0, in any state including mid-LOAD and mid-READ.
REQ-032 After rstn rises, no output SHALL change until a new start_load is sampled; partial tiles are discarded.

Verification (SYS_COLS = 4, ROWS = 3, W_BITWIDTH = 8)
REQ-033 start_load, then 12 back-to-back words 0x01..0x0C -> wr_en = 0001 for 0x01..0x03, 0010 for 0x04..0x06, 0100 for 0x07..0x09, 1000 for 0x0A..0x0C; load_done with 0x0C write; state LOADED.
REQ-034 Same load with w_valid low every other cycle -> identical wr_en/wr_data sequence, 12 writes total, load_done once.
REQ-035 From LOADED, start_read at cycle T -> read high T+1..T+3, DRAIN T+4..T+6, read_done at T+6, busy low at T+7.
REQ-036 start_read in IDLE, and start_load during READ -> no state change, no outputs driven, busy unchanged.
REQ-037 rstn low after 5 accepted words, release, start_load, 12 words -> first write goes to wr_en = 0001 with the first new word; exactly 12 writes.
REQ-038 start_load and start_read together in IDLE -> LOAD entered, w_ready = 1 next cycle, read stays 0.
